// File: rtl/video_stream_gen_pkg.sv
// Shared types and constants for the video stream generator.
package video_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } state_t;

  localparam logic [1:0] PAT_RAMP    = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_CONST   = 2'd2;
  localparam logic [1:0] PAT_MARKER  = 2'd3;

endpackage

// File: rtl/video_stream_gen_pix.sv
// Combinational pixel function: maps a raster position and pattern code to a pixel.
module video_pattern_pix
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int X          = 1,
  parameter int Y          = 1,
  parameter int KERNAL     = 3
) (
  input  logic [CNT_W-1:0]      col,
  input  logic [CNT_W-1:0]      row,
  input  logic [1:0]            pattern,
  input  logic [DATA_WIDTH-1:0] const_val,
  output logic [DATA_WIDTH-1:0] pix
);

  // Top-left corner of the marker window; may be negative when the centre hugs an edge
  localparam int X0 = X - KERNAL / 2;
  localparam int Y0 = Y - KERNAL / 2;

  logic [CNT_W:0] ramp_sum;
  int             dx;
  int             dy;
  logic           in_win;

  // Select the pixel value for the requested pattern at (col,row)
  always_comb begin
    pix      = '0;
    ramp_sum = {1'b0, col} + {1'b0, row};
    dx       = int'(col) - X0;
    dy       = int'(row) - Y0;
    in_win   = (dx >= 0) && (dx < KERNAL) && (dy >= 0) && (dy < KERNAL);
    unique case (pattern)
      PAT_RAMP:    pix = DATA_WIDTH'(ramp_sum);
      PAT_CHECKER: pix = (col[3] ^ row[3]) ? '1 : '0;
      PAT_CONST:   pix = const_val;
      PAT_MARKER:  pix = in_win ? DATA_WIDTH'(dy * KERNAL + dx + 1) : '0;
      default:     pix = '0;
    endcase
  end

endmodule

// File: rtl/video_stream_gen.sv
// AXI4-Stream raster test-pattern master with SOF on tuser and EOL on tlast.
// Optional macro VIDEO_STREAM_GEN_FRAME_CNT_EN adds a frame counter output
// and mixes it into the constant pattern so successive frames differ.
module video_stream_gen
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 16,
  parameter int X          = 1,
  parameter int Y          = 1,
  parameter int KERNAL     = 3
) (
  input  logic                  m_axis_clk,
  input  logic                  m_axis_rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] const_val,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tlast,
  output logic                  busy
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_HEIGHT - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_BLANK - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      col, row, blank_cnt;
  logic [CNT_W-1:0]      col_n, row_n, blank_n;
  logic [1:0]            pat_q, pat_n;
  logic [DATA_WIDTH-1:0] const_q, const_n;
  logic [DATA_WIDTH-1:0] pix_n;
  logic [DATA_WIDTH-1:0] frame_mask;
  logic                  start, frame_end, last_beat, active_n;

  assign busy      = (state != IDLE);
  assign last_beat = (state == ACTIVE) && m_axis_tready &&
                     (col == LAST_COL) && (row == LAST_ROW);
  assign active_n  = (state_n == ACTIVE);

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [15:0]            frame_cnt_n;
  logic [DATA_WIDTH+15:0] fc_ext;

  // Frame count as it will stand once this cycle's last beat (if any) is counted
  always_comb begin
    frame_cnt_n = frame_cnt + 16'(last_beat);
    fc_ext      = {{DATA_WIDTH{1'b0}}, frame_cnt_n};
    frame_mask  = fc_ext[DATA_WIDTH-1:0];
  end

  // Frame counter, bumped when the final pixel of a frame handshakes
  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) frame_cnt <= '0;
    else            frame_cnt <= frame_cnt_n;
  end
`else
  assign frame_mask = '0;
`endif

  // Next-state, raster counters, blanking countdown and frame-start latching
  always_comb begin
    state_n   = state;
    col_n     = col;
    row_n     = row;
    blank_n   = blank_cnt;
    pat_n     = pat_q;
    const_n   = const_q;
    start     = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      IDLE: start = enable;
      ACTIVE: begin
        if (m_axis_tready) begin
          if (col != LAST_COL) begin
            col_n = col + 1'b1;
          end else if (row != LAST_ROW) begin
            col_n = '0;
            row_n = row + 1'b1;
            if (H_BLANK > 0) begin
              state_n = HBLANK;
              blank_n = '0;
            end
          end else begin
            col_n = '0;
            row_n = '0;
            if (V_BLANK > 0) begin
              state_n = VBLANK;
              blank_n = '0;
            end else begin
              frame_end = 1'b1;
            end
          end
        end
      end
      HBLANK: begin
        if (blank_cnt == H_LAST) state_n = ACTIVE;
        else                     blank_n = blank_cnt + 1'b1;
      end
      VBLANK: begin
        if (blank_cnt == V_LAST) frame_end = 1'b1;
        else                     blank_n   = blank_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (frame_end) begin
      if (enable) start   = 1'b1;
      else        state_n = IDLE;
    end
    if (start) begin
      state_n = ACTIVE;
      col_n   = '0;
      row_n   = '0;
      pat_n   = pattern_sel;
      const_n = const_val ^ frame_mask;
    end
  end

  video_pattern_pix #(
    .DATA_WIDTH (DATA_WIDTH),
    .X          (X),
    .Y          (Y),
    .KERNAL     (KERNAL)
  ) u_pix (
    .col        (col_n),
    .row        (row_n),
    .pattern    (pat_n),
    .const_val  (const_n),
    .pix        (pix_n)
  );

  // State, counters and registered stream outputs computed from the next position
  always_ff @(posedge m_axis_clk) begin
    if (m_axis_rst) begin
      state         <= IDLE;
      col           <= '0;
      row           <= '0;
      blank_cnt     <= '0;
      pat_q         <= '0;
      const_q       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_n;
      col           <= col_n;
      row           <= row_n;
      blank_cnt     <= blank_n;
      pat_q         <= pat_n;
      const_q       <= const_n;
      m_axis_tvalid <= active_n;
      m_axis_tdata  <= active_n ? pix_n : '0;
      m_axis_tuser  <= active_n && (col_n == '0) && (row_n == '0);
      m_axis_tlast  <= active_n && (col_n == LAST_COL);
    end
  end

endmodule

// File: tb/tb_video_stream_gen.sv
// Self-checking bench for video_stream_gen: two instances (no blanking 4x3,
// blanked 5x4 with an offset marker) driven by shared stimulus and checked
// every cycle against a position-index model, plus literal pinned frames.
module tb_video_stream_gen;

  localparam int NI = 2;
  localparam int A_W = 4, A_H = 3, A_HB = 0, A_VB = 0, A_X = 1, A_Y = 1;
  localparam int B_W = 5, B_H = 4, B_HB = 2, B_VB = 3, B_X = 2, B_Y = 1;
  localparam int MK  = 3;
  localparam int MW  [NI] = '{A_W, B_W};
  localparam int MH  [NI] = '{A_H, B_H};
  localparam int MHB [NI] = '{A_HB, B_HB};
  localparam int MVB [NI] = '{A_VB, B_VB};
  localparam int MX  [NI] = '{A_X, B_X};
  localparam int MY  [NI] = '{A_Y, B_Y};
  localparam int RAMP_EXP [12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
  localparam int MARK_EXP [20] = '{0, 1, 2, 3, 0,
                                   0, 4, 5, 6, 0,
                                   0, 7, 8, 9, 0,
                                   0, 0, 0, 0, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       rdy = 1'b1;
  logic [1:0] pat = 2'd0;
  logic [7:0] cv  = 8'd0;

  logic       a_valid, a_user, a_last, a_busy;
  logic [7:0] a_data;
  logic       b_valid, b_user, b_last, b_busy;
  logic [7:0] b_data;
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
  logic [15:0] a_fc, b_fc;
`endif

  int checks = 0;
  int errors = 0;
  int check_on = 0;

  int m_run [NI], m_valid [NI], m_pos [NI], m_gap [NI], m_vb [NI];
  int m_pat [NI], m_cst [NI], m_fc [NI];

  logic [7:0] a_cap_d [$];
  logic       a_cap_u [$];
  logic       a_cap_l [$];
  logic [7:0] b_cap_d [$];
  int a_sof = 0;

  int gap_on = 0, gap_pend = 0, gap_cnt = 0, gap_final = 0, b_line = 0, gap_checks = 0;

  always #5 clk = ~clk;

  video_stream_gen #(
    .DATA_WIDTH(8), .IMG_WIDTH(A_W), .IMG_HEIGHT(A_H), .H_BLANK(A_HB),
    .V_BLANK(A_VB), .X(A_X), .Y(A_Y), .KERNAL(MK)
  ) u_a (
    .m_axis_clk(clk), .m_axis_rst(rst), .enable(en), .pattern_sel(pat),
    .const_val(cv), .m_axis_tready(rdy), .m_axis_tvalid(a_valid),
    .m_axis_tdata(a_data), .m_axis_tuser(a_user), .m_axis_tlast(a_last),
    .busy(a_busy)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(a_fc)
`endif
  );

  video_stream_gen #(
    .DATA_WIDTH(8), .IMG_WIDTH(B_W), .IMG_HEIGHT(B_H), .H_BLANK(B_HB),
    .V_BLANK(B_VB), .X(B_X), .Y(B_Y), .KERNAL(MK)
  ) u_b (
    .m_axis_clk(clk), .m_axis_rst(rst), .enable(en), .pattern_sel(pat),
    .const_val(cv), .m_axis_tready(rdy), .m_axis_tvalid(b_valid),
    .m_axis_tdata(b_data), .m_axis_tuser(b_user), .m_axis_tlast(b_last),
    .busy(b_busy)
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    , .frame_cnt(b_fc)
`endif
  );

  task automatic checkOutput(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d actual %0d expected %0d", name, inst, act, exp);
    end
  endtask

  // Expected pixel for position index pos of instance i, from the pattern rules
  function automatic int exp_pix(input int i, input int pos);
    int c, r, dx, dy, res;
    c   = pos % MW[i];
    r   = pos / MW[i];
    res = 0;
    case (m_pat[i])
      0: res = (c + r) % 256;
      1: res = ((((c / 8) ^ (r / 8)) % 2) == 1) ? 255 : 0;
      2: res = m_cst[i];
      default: begin
        dx = c - (MX[i] - MK / 2);
        dy = r - (MY[i] - MK / 2);
        if (dx >= 0 && dx < MK && dy >= 0 && dy < MK) res = (dy * MK + dx + 1) % 256;
      end
    endcase
    return res;
  endfunction

  task automatic start_frame(input int i);
    m_run[i]   = 1;
    m_valid[i] = 1;
    m_pos[i]   = 0;
    m_vb[i]    = 0;
    m_pat[i]   = int'(pat);
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    m_cst[i]   = int'(cv) ^ (m_fc[i] % 256);
`else
    m_cst[i]   = int'(cv);
`endif
  endtask

  task automatic frame_end(input int i);
    if (en) start_frame(i);
    else begin
      m_run[i]   = 0;
      m_valid[i] = 0;
    end
  endtask

  // Advance the model across one clock edge using the inputs sampled there
  task automatic advance_model(input int i);
    if (rst) begin
      m_run[i] = 0; m_valid[i] = 0; m_pos[i] = 0; m_gap[i] = 0; m_vb[i] = 0; m_fc[i] = 0;
    end else if (m_run[i] == 0) begin
      if (en) start_frame(i);
    end else if (m_valid[i] == 1) begin
      if (rdy) begin
        if (m_pos[i] == MW[i] * MH[i] - 1) begin
          m_fc[i] = (m_fc[i] + 1) % 65536;
          if (MVB[i] > 0) begin
            m_valid[i] = 0; m_vb[i] = 1; m_gap[i] = MVB[i];
          end else frame_end(i);
        end else begin
          m_pos[i]++;
          if ((m_pos[i] % MW[i]) == 0 && MHB[i] > 0) begin
            m_valid[i] = 0; m_gap[i] = MHB[i];
          end
        end
      end
    end else begin
      m_gap[i]--;
      if (m_gap[i] == 0) begin
        if (m_vb[i] == 1) begin
          m_vb[i] = 0;
          frame_end(i);
        end else m_valid[i] = 1;
      end
    end
  endtask

  task automatic get_out(input int i, output int v, output int d, output int u,
                         output int l, output int b, output int f);
    v = (i == 0) ? int'(a_valid) : int'(b_valid);
    d = (i == 0) ? int'(a_data)  : int'(b_data);
    u = (i == 0) ? int'(a_user)  : int'(b_user);
    l = (i == 0) ? int'(a_last)  : int'(b_last);
    b = (i == 0) ? int'(a_busy)  : int'(b_busy);
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    f = (i == 0) ? int'(a_fc) : int'(b_fc);
`else
    f = 0;
`endif
  endtask

  // One clock: compare at the falling edge, record beats, step the model, resume after the rising edge
  task automatic tick();
    int v, d, u, l, b, f;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      get_out(i, v, d, u, l, b, f);
      if (check_on == 1) begin
        checkOutput("tvalid", i, v, m_valid[i]);
        checkOutput("busy", i, b, m_run[i]);
        if (m_valid[i] == 1 && v == 1) begin
          checkOutput("tdata", i, d, exp_pix(i, m_pos[i]));
          checkOutput("tuser", i, u, (m_pos[i] == 0) ? 1 : 0);
          checkOutput("tlast", i, l, ((m_pos[i] % MW[i]) == MW[i] - 1) ? 1 : 0);
        end
`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
        checkOutput("frame_cnt", i, f, m_fc[i]);
`endif
      end
    end
    if (a_valid && rdy) begin
      a_cap_d.push_back(a_data);
      a_cap_u.push_back(a_user);
      a_cap_l.push_back(a_last);
      if (a_user) a_sof++;
    end
    if (b_valid && rdy) b_cap_d.push_back(b_data);
    if (gap_on == 1) begin
      if (b_valid) begin
        if (gap_pend == 1) begin
          checkOutput(gap_final == 1 ? "vblank_gap" : "hblank_gap", 1, gap_cnt, gap_final == 1 ? 3 : 2);
          if (gap_final == 1) checkOutput("sof_after_vblank", 1, int'(b_user), 1);
          gap_checks++;
          gap_pend = 0;
        end
        if (rdy) begin
          if (b_user) b_line = 0;
          if (b_last) begin
            gap_pend  = 1;
            gap_cnt   = 0;
            gap_final = (b_line == B_H - 1) ? 1 : 0;
            b_line++;
          end
        end
      end else if (gap_pend == 1) gap_cnt++;
    end
    for (int i = 0; i < NI; i++) advance_model(i);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] p, input logic [7:0] c,
                               input logic r, input logic s);
    en  = e;
    pat = p;
    cv  = c;
    rdy = r;
    rst = s;
    tick();
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < 300) begin
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    if (a_busy || b_busy) checkOutput(name, 0, 0, 1);
  endtask

  task automatic clearCaptures();
    a_cap_d.delete();
    a_cap_u.delete();
    a_cap_l.delete();
    b_cap_d.delete();
    a_sof = 0;
  endtask

  task automatic checkRampFrame(input string name);
    checkOutput(name, 0, a_cap_d.size(), 12);
    for (int j = 0; j < 12; j++) begin
      if (j < a_cap_d.size()) begin
        checkOutput("ramp_data", j, int'(a_cap_d[j]), RAMP_EXP[j]);
        checkOutput("ramp_user", j, int'(a_cap_u[j]), (j == 0) ? 1 : 0);
        checkOutput("ramp_last", j, int'(a_cap_l[j]), (j % 4 == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int n;
    logic en_r;
    en_r = 1'b0;
    repeat (3) applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b1);
    check_on = 1;
    applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("reset_tvalid", 0, int'(a_valid), 0);
    checkOutput("reset_busy", 0, int'(a_busy), 0);
    checkOutput("reset_tdata", 0, int'(a_data), 0);
    checkOutput("reset_tuser", 0, int'(a_user), 0);
    checkOutput("reset_tlast", 1, int'(b_last), 0);
    checkOutput("reset_busy", 1, int'(b_busy), 0);

    // Ramp frame with a one-cycle enable pulse
    clearCaptures();
    applyStimulus(1'b1, 2'd0, 8'd0, 1'b1, 1'b0);
    repeat (20) applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
    checkRampFrame("ramp_beats");
    checkOutput("ramp_idle_busy", 0, int'(a_busy), 0);
    waitIdle("timeout_ramp");

    // Same frame under a 1,0,0,1 ready pattern
    clearCaptures();
    for (int k = 0; k < 80; k++)
      applyStimulus(k == 0, 2'd0, 8'd0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
    checkRampFrame("bp_beats");
    waitIdle("timeout_bp");

    // Marker window on the 5x4 instance
    clearCaptures();
    applyStimulus(1'b1, 2'd3, 8'd0, 1'b1, 1'b0);
    repeat (40) applyStimulus(1'b0, 2'd3, 8'd0, 1'b1, 1'b0);
    checkOutput("marker_beats", 1, b_cap_d.size(), 20);
    for (int j = 0; j < 20; j++)
      if (j < b_cap_d.size()) checkOutput("marker_data", j, int'(b_cap_d[j]), MARK_EXP[j]);
    waitIdle("timeout_marker");

    // Blanking gaps with enable held high
    gap_on = 1; gap_pend = 0; b_line = 0; gap_checks = 0;
    for (int k = 0; k < 100; k++)
      applyStimulus(1'b1, 2'($urandom_range(0, 3)), 8'($urandom), 1'b1, 1'b0);
    gap_on = 0;
    checkOutput("gaps_seen", 1, (gap_checks >= 5) ? 1 : 0, 1);
    waitIdle("timeout_blank");

    // Enable dropped mid-frame: the frame still completes
    clearCaptures();
    n = 0;
    while (a_cap_d.size() < 5 && n < 60) begin
      applyStimulus(1'b1, 2'd0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    waitIdle("timeout_drop");
    checkOutput("drop_beats", 0, a_cap_d.size(), 12);

    // Reset mid-frame abandons the frame; next enable restarts at (0,0)
    clearCaptures();
    applyStimulus(1'b1, 2'd0, 8'd0, 1'b1, 1'b0);
    n = 0;
    while (a_cap_d.size() < 6 && n < 60) begin
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b1);
    checkOutput("rst_mid_tvalid", 0, int'(a_valid), 0);
    checkOutput("rst_mid_busy", 0, int'(a_busy), 0);
    clearCaptures();
    applyStimulus(1'b1, 2'd0, 8'd0, 1'b1, 1'b0);
    n = 0;
    while (a_cap_d.size() < 1 && n < 20) begin
      applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("restart_seen", 0, (a_cap_d.size() >= 1) ? 1 : 0, 1);
    if (a_cap_d.size() >= 1) begin
      checkOutput("restart_tuser", 0, int'(a_cap_u[0]), 1);
      checkOutput("restart_tdata", 0, int'(a_cap_d[0]), 0);
    end
    waitIdle("timeout_restart");

    // Randomized traffic, patterns, ready and occasional reset
    for (int k = 0; k < 1500; k++) begin
      if (k % 25 == 0) en_r = 1'($urandom_range(0, 1));
      applyStimulus(en_r, 2'($urandom_range(0, 3)), 8'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    end
    waitIdle("timeout_random");

`ifdef VIDEO_STREAM_GEN_FRAME_CNT_EN
    // Three constant frames: counter steps and per-frame XOR
    applyStimulus(1'b0, 2'd0, 8'd0, 1'b1, 1'b1);
    clearCaptures();
    n = 0;
    while (a_sof < 3 && n < 200) begin
      applyStimulus(1'b1, 2'd2, 8'hA5, 1'b1, 1'b0);
      n++;
    end
    waitIdle("timeout_fc");
    checkOutput("fc_final", 0, int'(a_fc), 3);
    checkOutput("fc_beats", 0, a_cap_d.size(), 36);
    for (int j = 0; j < 36; j++)
      if (j < a_cap_d.size())
        checkOutput("fc_pixel", j, int'(a_cap_d[j]), (j < 12) ? 8'hA5 : (j < 24) ? 8'hA4 : 8'hA7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
